vec_alu_engine: RTL
===================

# vec_alu_engine

Multi-op vector ALU engine that streams operand vectors A and B out of a shared single-port BRAM, applies a selectable element-wise operation and writes the result vector back into the same BRAM. It is the parametrised successor to the fixed vector-add compute block. It sits behind the host control registers on BRAM port B. It adds an opcode, a configurable BRAM read latency, signed compare ops, a unary op that skips the B read, and busy/error status.

## Interface
- ADDR_WIDTH, 13, BRAM word-address width
- DATA_WIDTH, 32, element and BRAM data width
- RD_LATENCY, 2, BRAM cycles from registered en/addr to valid dout (≥1)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  launch request; sampled only in IDLE
- op  in  3  000 ADD, 001 SUB (a−b), 010 MUL (low DATA_WIDTH bits), 011 MAX signed, 100 MIN signed, 101 RELU (signed max(a,0), unary), 110/111 illegal
- addr_a, addr_b, addr_out  in  ADDR_WIDTH  vector base addresses
- len  in  32  element count
- busy  out  1  high from the cycle after start acceptance through the DONE state
- done  out  1  one-cycle completion pulse
- error  out  1  sticky; set on illegal op; cleared on the next accepted start
- bram_addr_b  out  ADDR_WIDTH, bram_din_b  out  DATA_WIDTH, bram_dout_b  in  DATA_WIDTH, bram_en_b  out  1, bram_we_b  out  1

## Operation
- Reset: state IDLE; all outputs 0; internal index, operand registers and latched config 0.
- IDLE + start: latch op, addr_a, addr_b, addr_out and len. Later changes to these inputs are ignored until the next start.
  - If op is illegal: set error and go to DONE. No BRAM access.
  - Else if len == 0: go to DONE. No BRAM access.
  - Else: set i = 0 and go to ISSUE_A.
- States and transitions:
  - IDLE: waits for start as above.
  - ISSUE_A: drives en=1, we=0, addr=addr_a+i, then goes to WAIT_A.
  - WAIT_A: lasts RD_LATENCY cycles. On the last cycle it captures dout into a. It then goes to ISSUE_B, or to WRITE when op is RELU.
  - ISSUE_B / WAIT_B: same pattern as A, using addr_b+i and capturing into b.
  - WRITE: drives en=1, we=1, addr=addr_out+i, din=result. If i == len−1 it goes to DONE; otherwise it increments i and goes to ISSUE_A.
  - DONE: asserts done for one cycle, then returns to IDLE.
- bram_en_b and bram_we_b default to 0 in every state that does not drive them. bram_addr_b and bram_din_b hold their last value.
- Address arithmetic is modulo 2^ADDR_WIDTH and wraps silently.
- Arithmetic:
  - ADD, SUB and MUL wrap modulo 2^DATA_WIDTH.
  - MAX, MIN and RELU use two's-complement signed compare.
- Overlap: out may alias A or B. Element i is fully read before it is written, so in-place updates are correct.
- start while busy is ignored. Reset mid-operation aborts immediately with no further BRAM writes.

## Timing
- All outputs are registered.
- Cycles per element: binary op = 2·(1+RD_LATENCY)+1 (7 at default); RELU = (1+RD_LATENCY)+1 (4 at default).
- Let the start-sampling edge be edge 0 and E be the per-element cycle count:
  - The first ISSUE_A drive is visible after edge 1.
  - The last write is visible after edge N·E.
  - done is high for the one cycle following edge N·E+2.
- len == 0 or an illegal op: done is high for the one cycle following edge 2.
- Back-to-back starts: start may be high in the cycle done is high, but it is only accepted once state is IDLE, i.e. on the edge after the done cycle.

## Configuration
- VEC_ALU_SAT_EN defined:
  - ADD and SUB saturate to the signed DATA_WIDTH range: max 2^(DATA_WIDTH−1)−1, min −2^(DATA_WIDTH−1).
  - MUL saturates when the full 2·DATA_WIDTH signed product exceeds that range.
- Undefined: all arithmetic wraps. Saturation logic is absent.
- Compare ops and timing are identical in both builds.

## Test plan
- ADD, len=4, A=[1,2,3,0x7FFFFFFF], B=[10,20,30,1] -> C=[11,22,33,0x80000000]; with VEC_ALU_SAT_EN, C[3]=0x7FFFFFFF. done after edge 30 (7·4+2).
- MAX/MIN, A=[−5,7], B=[3,−9] -> MAX=[3,7], MIN=[−5,−9].
- RELU, len=3, A=[−1,0,42] -> C=[0,0,42]. No B-address reads ever issued. done after edge 14.
- Illegal op=110, len=8 -> zero BRAM enables, error=1, done after edge 2. A following legal start clears error.
- len=0 -> no BRAM access, done after edge 2. A start pulse during busy has no effect.
- In-place ADD with addr_out=addr_a=0x1FFE, len=3 -> addresses wrap to 0x0000, and A[i] is overwritten with A[i]+B[i].
- Reset asserted mid-run -> all outputs 0 immediately, no further writes.

Source files
------------

// File: rtl/vec_alu_engine.sv
// rtl/vec_alu_engine.sv - element-wise vector ALU streaming operands through a shared single-port BRAM
//
// Reads A[i] (and B[i] for binary ops) from BRAM port B, computes one result per element
// and writes it back to addr_out+i. Optional build macro: VEC_ALU_SAT_EN (saturating ADD/SUB/MUL).
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   start                           launch request, sampled only while idle
//   op[2:0]                         0 ADD, 1 SUB, 2 MUL, 3 MAX, 4 MIN, 5 RELU, 6/7 illegal
//   addr_a, addr_b, addr_out        vector base word addresses
//   len[31:0]                       element count
//   busy, done, error               status: running, one-cycle completion, sticky illegal-op flag
//   bram_addr_b, bram_din_b,
//   bram_dout_b, bram_en_b,
//   bram_we_b                       BRAM port B
module vec_alu_engine #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [ADDR_WIDTH-1:0] addr_out,
  input  logic [31:0]           len,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] bram_addr_b,
  output logic [DATA_WIDTH-1:0] bram_din_b,
  input  logic [DATA_WIDTH-1:0] bram_dout_b,
  output logic                  bram_en_b,
  output logic                  bram_we_b
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE_A = 3'd1;
  localparam logic [2:0] S_WAIT_A  = 3'd2;
  localparam logic [2:0] S_ISSUE_B = 3'd3;
  localparam logic [2:0] S_WAIT_B  = 3'd4;
  localparam logic [2:0] S_WRITE   = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_MUL  = 3'd2;
  localparam logic [2:0] OP_MAX  = 3'd3;
  localparam logic [2:0] OP_MIN  = 3'd4;
  localparam logic [2:0] OP_RELU = 3'd5;

  // Last count value of a read wait window; DONE reuses the counter for its two cycles.
  localparam logic [7:0] CNT_LAST = 8'(RD_LATENCY - 1);

`ifdef VEC_ALU_SAT_EN
  localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
`endif

  logic [2:0]            state;
  logic [2:0]            op_q;
  logic [ADDR_WIDTH-1:0] addr_a_q;
  logic [ADDR_WIDTH-1:0] addr_b_q;
  logic [ADDR_WIDTH-1:0] addr_out_q;
  logic [31:0]           len_q;
  logic [31:0]           idx;
  logic [7:0]            cnt;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [DATA_WIDTH-1:0] result;
  logic                  a_lt_b;

`ifdef VEC_ALU_SAT_EN
  // One guard bit catches signed overflow of ADD/SUB; the full product covers MUL.
  logic [DATA_WIDTH:0]            sum_x;
  logic [DATA_WIDTH:0]            dif_x;
  logic signed [2*DATA_WIDTH-1:0] prod_x;
  logic [DATA_WIDTH:0]            prod_top;
`endif

  always_comb begin
    a_lt_b = $signed(a_q) < $signed(b_q);
    result = '0;
`ifdef VEC_ALU_SAT_EN
    sum_x    = {a_q[DATA_WIDTH-1], a_q} + {b_q[DATA_WIDTH-1], b_q};
    dif_x    = {a_q[DATA_WIDTH-1], a_q} - {b_q[DATA_WIDTH-1], b_q};
    prod_x   = $signed(a_q) * $signed(b_q);
    prod_top = prod_x[2*DATA_WIDTH-1:DATA_WIDTH-1];
`endif
    case (op_q)
`ifdef VEC_ALU_SAT_EN
      OP_ADD: begin
        result = sum_x[DATA_WIDTH-1:0];
        if (sum_x[DATA_WIDTH] != sum_x[DATA_WIDTH-1]) result = sum_x[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
      end
      OP_SUB: begin
        result = dif_x[DATA_WIDTH-1:0];
        if (dif_x[DATA_WIDTH] != dif_x[DATA_WIDTH-1]) result = dif_x[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
      end
      OP_MUL: begin
        result = prod_x[DATA_WIDTH-1:0];
        // The product fits only if its top DATA_WIDTH+1 bits are a pure sign extension.
        if (!((&prod_top) || (~|prod_top))) result = prod_x[2*DATA_WIDTH-1] ? SAT_MIN : SAT_MAX;
      end
`else
      OP_ADD:  result = a_q + b_q;
      OP_SUB:  result = a_q - b_q;
      OP_MUL:  result = a_q * b_q;
`endif
      OP_MAX:  result = a_lt_b ? b_q : a_q;
      OP_MIN:  result = a_lt_b ? a_q : b_q;
      OP_RELU: result = a_q[DATA_WIDTH-1] ? '0 : a_q;
      default: result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      op_q        <= '0;
      addr_a_q    <= '0;
      addr_b_q    <= '0;
      addr_out_q  <= '0;
      len_q       <= '0;
      idx         <= '0;
      cnt         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      bram_addr_b <= '0;
      bram_din_b  <= '0;
      bram_en_b   <= 1'b0;
      bram_we_b   <= 1'b0;
    end else begin
      // Strobes are single-cycle; address and data registers hold between accesses.
      bram_en_b <= 1'b0;
      bram_we_b <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q       <= op;
            addr_a_q   <= addr_a;
            addr_b_q   <= addr_b;
            addr_out_q <= addr_out;
            len_q      <= len;
            idx        <= '0;
            cnt        <= '0;
            busy       <= 1'b1;
            error      <= (op > OP_RELU);
            if (op > OP_RELU || len == 32'd0) state <= S_DONE;
            else                              state <= S_ISSUE_A;
          end
        end
        S_ISSUE_A: begin
          bram_en_b   <= 1'b1;
          bram_addr_b <= addr_a_q + idx[ADDR_WIDTH-1:0];
          cnt         <= '0;
          state       <= S_WAIT_A;
        end
        S_WAIT_A: begin
          if (cnt == CNT_LAST) begin
            a_q   <= bram_dout_b;
            state <= (op_q == OP_RELU) ? S_WRITE : S_ISSUE_B;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_ISSUE_B: begin
          bram_en_b   <= 1'b1;
          bram_addr_b <= addr_b_q + idx[ADDR_WIDTH-1:0];
          cnt         <= '0;
          state       <= S_WAIT_B;
        end
        S_WAIT_B: begin
          if (cnt == CNT_LAST) begin
            b_q   <= bram_dout_b;
            state <= S_WRITE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_WRITE: begin
          bram_en_b   <= 1'b1;
          bram_we_b   <= 1'b1;
          bram_addr_b <= addr_out_q + idx[ADDR_WIDTH-1:0];
          bram_din_b  <= result;
          if (idx == len_q - 32'd1) begin
            cnt   <= '0;
            state <= S_DONE;
          end else begin
            idx   <= idx + 32'd1;
            state <= S_ISSUE_A;
          end
        end
        S_DONE: begin
          // Two cycles in DONE so the done pulse lands two edges after the final write.
          if (cnt == 8'd1) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
